uart_dec_rx: RTL
================

Name: uart_dec_rx

Overview:
UART receiver with an ASCII-decimal line parser. It accepts a decimal value typed over the USB-RS232 link as digits terminated by CR, for example "1234\r". This is the same format the board's UART transmitter emits. The block converts the line to binary and presents it as a DATA_W-bit value with a one-cycle update strobe, for use as a DAC or reference setpoint. Raw received bytes and error pulses are also exported for debug and LED display.

Parameters:
CLK_FREQ_HZ, 100000000, system clock frequency
BAUD, 115200, line rate; CLKS_PER_BIT = CLK_FREQ_HZ/BAUD (integer division, 868 at defaults)
MAX_DIGITS, 4, maximum decimal digits accepted per line
DATA_W, 12, width of converted output value

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
rx_i  input  1  serial UART input, idle high, asynchronous to clk
byte_o  output  8  last correctly framed received byte
byte_valid_o  output  1  one-cycle pulse: byte_o updated
data_o  output  DATA_W  last accepted decimal value, binary
data_update_o  output  1  one-cycle pulse: data_o updated
frame_err_o  output  1  one-cycle pulse: stop bit sampled low
cmd_err_o  output  1  one-cycle pulse: line rejected at CR

Behaviour:
- Reset: all outputs 0; rx FSM in IDLE; accumulator, digit count and error flag cleared. Reset mid-frame aborts the frame; nothing is emitted.
- rx_i passes through a 2-FF synchronizer (reset value 1). All decisions use the synchronized signal.
- Rx FSM states and transitions:
  - IDLE: falling edge (sync line 0) -> START; bit counter loaded with CLKS_PER_BIT/2.
  - START: at half-bit, line 0 -> DATA; line 1 -> IDLE (glitch reject, no output).
  - DATA: 8 samples, one every CLKS_PER_BIT, LSB first, into a shift register -> STOP.
  - STOP: sample after CLKS_PER_BIT.
    - 1: byte_o <= shift reg; byte_valid_o pulses the next cycle -> IDLE.
    - 0: frame_err_o pulses; byte discarded; line error flag set -> BREAK.
  - BREAK: wait until line is 1 -> IDLE.
- Byte timing: byte_valid_o is asserted 1 clk after the stop-bit mid-sample.
- Parser acts on each byte_valid_o:
  - '0'..'9' (0x30-0x39), digit count < MAX_DIGITS: acc <= acc*10 + (byte-0x30); count++.
  - Digit with count == MAX_DIGITS: error flag set; acc unchanged.
  - 0x0A (LF): ignored.
  - 0x0D (CR): accept only if count > 0, error flag clear and acc <= 2^DATA_W-1.
    - Accept: data_o <= acc[DATA_W-1:0]; data_update_o pulses the cycle after the CR byte_valid_o.
    - Reject: cmd_err_o pulses the same cycle instead; data_o holds.
    - Either case clears acc, count and error flag.
  - Any other byte: error flag set.
- acc width is ceil(log2(10^MAX_DIGITS)), i.e. 14 bits at defaults; no wrap is possible.
- data_update_o and cmd_err_o are mutually exclusive. frame_err_o may coincide with neither, since it is on a different byte.
- A new start bit is accepted immediately after STOP returns to IDLE. Back-to-back frames with no idle gap are supported.

Test Plan:
- "1234\r" at 115200 8N1 -> five byte_valid_o pulses with byte_o 0x31,0x32,0x33,0x34,0x0D; data_o=0x4D2 with one data_update_o pulse ~1 clk after CR; no errors.
- "4095\r\n" then "4096\r" -> data_o=0xFFF with update; second line gives cmd_err_o, data_o stays 0xFFF; LF produces no error.
- "12a4\r", "12345\r", lone "\r" -> cmd_err_o once per line, no data_update_o, data_o unchanged; then "7\r" -> data_o=7.
- Frame with stop bit 0, line held low 3 bit times, then "0005\r" -> frame_err_o once, that partial line's CR gives cmd_err_o; next "0005\r" -> data_o=5.
- rx_i low glitch of 100 clks -> no byte_valid_o, FSM back in IDLE; following valid "9\r" decodes to 9.
- rst_n asserted mid-DATA of "8" then released, then "8\r" sent -> outputs 0 during reset; only one data_update_o, with data_o=8.

Source files
------------

// File: rtl/uart_dec_rx.sv
// UART 8N1 receiver feeding an ASCII-decimal line parser ("1234\r" -> 1234).
// Raw bytes, the converted value and error pulses are all single-cycle registered strobes.
module uart_dec_rx #(
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int BAUD        = 115200,
    parameter int MAX_DIGITS  = 4,
    parameter int DATA_W      = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_i,
    output logic [7:0]        byte_o,
    output logic              byte_valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic              data_update_o,
    output logic              frame_err_o,
    output logic              cmd_err_o
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam int ACC_W        = $clog2(10 ** MAX_DIGITS);
    localparam int DIG_W        = $clog2(MAX_DIGITS + 1);

    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);
    localparam longint unsigned  MAX_VAL  = (64'd1 << DATA_W) - 64'd1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_e;

    // Receive handshake: byte_valid_o is a one-cycle strobe with byte_o stable from
    // that cycle on; there is no back-pressure, the parser consumes every strobe.

    logic [1:0] sync_q;
    logic       rx_s;

    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] tick_q, tick_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       byte_q, byte_d;
    logic             byte_valid_q, byte_valid_d;
    logic             frame_err_q, frame_err_d;

    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [DIG_W-1:0]  dig_q, dig_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              data_update_q, data_update_d;
    logic              cmd_err_q, cmd_err_d;

    logic [ACC_W-1:0] acc_x10;
    logic [ACC_W-1:0] digit_val;
    logic             is_digit;
    logic             acc_fits;

    // Reset value 1 keeps the idle line from looking like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx_i};
        end
    end

    assign rx_s = sync_q[1];

    always_comb begin
        state_d      = state_q;
        tick_d       = tick_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        byte_d       = byte_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d = ST_START;
                    tick_d  = HALF_BIT;
                end
            end
            ST_START: begin
                if (tick_q != '0) begin
                    tick_d = tick_q - 1'b1;
                end else if (rx_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DATA;
                    tick_d  = FULL_BIT;
                    bit_d   = 3'd0;
                end
            end
            ST_DATA: begin
                if (tick_q != '0) begin
                    tick_d = tick_q - 1'b1;
                end else begin
                    shift_d = {rx_s, shift_q[7:1]};
                    tick_d  = FULL_BIT;
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (tick_q != '0) begin
                    tick_d = tick_q - 1'b1;
                end else if (rx_s) begin
                    byte_d       = shift_q;
                    byte_valid_d = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    frame_err_d = 1'b1;
                    state_d     = ST_BREAK;
                end
            end
            ST_BREAK: begin
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            tick_q       <= '0;
            bit_q        <= 3'd0;
            shift_q      <= 8'h00;
            byte_q       <= 8'h00;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            byte_q       <= byte_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // acc*10 cannot overflow: a digit is only taken while acc < 10^(MAX_DIGITS-1).
    assign acc_x10   = (acc_q << 3) + (acc_q << 1);
    assign digit_val = {{(ACC_W-4){1'b0}}, byte_q[3:0]};
    assign is_digit  = (byte_q >= 8'h30) && (byte_q <= 8'h39);
    assign acc_fits  = (64'(acc_q) <= MAX_VAL);

    always_comb begin
        acc_d         = acc_q;
        dig_d         = dig_q;
        err_d         = err_q;
        data_d        = data_q;
        data_update_d = 1'b0;
        cmd_err_d     = 1'b0;
        if (frame_err_q) begin
            err_d = 1'b1;
        end
        if (byte_valid_q) begin
            if (is_digit) begin
                if (dig_q < DIG_W'(MAX_DIGITS)) begin
                    acc_d = acc_x10 + digit_val;
                    dig_d = dig_q + 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end else if (byte_q == 8'h0A) begin
                err_d = err_q;
            end else if (byte_q == 8'h0D) begin
                if ((dig_q != '0) && !err_q && acc_fits) begin
                    data_d        = DATA_W'(acc_q);
                    data_update_d = 1'b1;
                end else begin
                    cmd_err_d = 1'b1;
                end
                acc_d = '0;
                dig_d = '0;
                err_d = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q         <= '0;
            dig_q         <= '0;
            err_q         <= 1'b0;
            data_q        <= '0;
            data_update_q <= 1'b0;
            cmd_err_q     <= 1'b0;
        end else begin
            acc_q         <= acc_d;
            dig_q         <= dig_d;
            err_q         <= err_d;
            data_q        <= data_d;
            data_update_q <= data_update_d;
            cmd_err_q     <= cmd_err_d;
        end
    end

    assign byte_o        = byte_q;
    assign byte_valid_o  = byte_valid_q;
    assign data_o        = data_q;
    assign data_update_o = data_update_q;
    assign frame_err_o   = frame_err_q;
    assign cmd_err_o     = cmd_err_q;

endmodule
